// File: rtl/eeprom_rw_ctrl_pkg.sv
// Shared I2C parameters: master command bits and SCL timing, used by this sequencer
// and by the byte-level I2C master.
package eeprom_rw_ctrl_pkg;

    localparam logic [3:0] I2C_CMD_START = 4'b0001;
    localparam logic [3:0] I2C_CMD_WRITE = 4'b0010;
    localparam logic [3:0] I2C_CMD_READ  = 4'b0100;
    localparam logic [3:0] I2C_CMD_STOP  = 4'b1000;

    localparam int unsigned SYS_CLK_HZ = 50_000_000;
    localparam int unsigned I2C_SCL_HZ = 100_000;
    localparam int unsigned SCL_DIV    = SYS_CLK_HZ / (4 * I2C_SCL_HZ);

    // Data-phase command: READ or WRITE, with STOP attached to the final byte.
    function automatic logic [3:0] byte_cmd(input logic is_read, input logic is_last);
        byte_cmd = (is_read ? I2C_CMD_READ : I2C_CMD_WRITE) | (is_last ? I2C_CMD_STOP : 4'b0000);
    endfunction

endpackage

// File: rtl/eeprom_rw_ctrl.sv
// EEPROM transaction sequencer: turns read/write operations into the per-byte command
// stream of the I2C master and enforces the write-cycle time after each write.
module eeprom_rw_ctrl
    import eeprom_rw_ctrl_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = 7'b1010000,
    parameter int unsigned PAGE_SIZE = 16,
    parameter int unsigned LEN_W     = 5,
    parameter int unsigned TWR_CYC   = 250000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_req,
    input  logic             op_wr,
    input  logic [7:0]       op_addr,
    input  logic [LEN_W-1:0] op_len,
    output logic             op_rdy,
    input  logic [7:0]       wr_data,
    output logic             wr_data_ack,
    output logic [7:0]       rd_data,
    output logic             rd_vld,
    output logic             op_done,
    output logic             i2c_req,
    output logic [3:0]       i2c_cmd,
    output logic [7:0]       i2c_din,
    input  logic [7:0]       i2c_dout,
    input  logic             i2c_done
);

    localparam int TWR_W = $clog2(TWR_CYC + 1);

    typedef enum logic [6:0] {
        S_IDLE    = 7'b0000001,
        S_WR_DEV  = 7'b0000010,
        S_WR_ADDR = 7'b0000100,
        S_WR_DATA = 7'b0001000,
        S_RD_DEV  = 7'b0010000,
        S_RD_DATA = 7'b0100000,
        S_TWR     = 7'b1000000
    } state_t;

    state_t           state_reg;
    logic             op_wr_reg;
    logic [7:0]       op_addr_reg;
    logic [LEN_W-1:0] last_idx_reg;
    logic [LEN_W-1:0] cnt_byte_reg;
    logic             cmd_pend_reg;
    logic             fin_reg;
    logic [TWR_W-1:0] twr_cnt_reg;

    logic             cmd_done;
    logic             last_byte;
    logic [LEN_W-1:0] next_idx;
    logic             next_last;

    // Only a done that answers an issued command may move the sequence on.
    assign cmd_done  = cmd_pend_reg && i2c_done;
    assign last_byte = (cnt_byte_reg == last_idx_reg);
    assign next_idx  = (state_reg == S_WR_DATA || state_reg == S_RD_DATA)
                       ? cnt_byte_reg + LEN_W'(1) : '0;
    assign next_last = (next_idx == last_idx_reg);

    // Combinational so the byte is taken in the same cycle the next WRITE is registered.
    assign wr_data_ack = cmd_done &&
                         ((state_reg == S_WR_ADDR && op_wr_reg) ||
                          (state_reg == S_WR_DATA && !last_byte));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            op_rdy       <= 1'b1;
            op_wr_reg    <= 1'b0;
            op_addr_reg  <= '0;
            last_idx_reg <= '0;
            cnt_byte_reg <= '0;
            cmd_pend_reg <= 1'b0;
            fin_reg      <= 1'b0;
            twr_cnt_reg  <= '0;
            i2c_req      <= 1'b0;
            i2c_cmd      <= '0;
            i2c_din      <= '0;
            rd_data      <= '0;
            rd_vld       <= 1'b0;
            op_done      <= 1'b0;
        end else begin
            i2c_req <= 1'b0;
            rd_vld  <= 1'b0;
            op_done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (op_req) begin
                        op_wr_reg    <= op_wr;
                        op_addr_reg  <= op_addr;
                        cnt_byte_reg <= '0;
                        if (op_len == '0)
                            last_idx_reg <= '0;
                        else if (op_len > LEN_W'(PAGE_SIZE))
                            last_idx_reg <= LEN_W'(PAGE_SIZE - 1);
                        else
                            last_idx_reg <= op_len - LEN_W'(1);
                        op_rdy       <= 1'b0;
                        state_reg    <= S_WR_DEV;
                        cmd_pend_reg <= 1'b1;
                        i2c_req      <= 1'b1;
                        i2c_cmd      <= I2C_CMD_START | I2C_CMD_WRITE;
                        i2c_din      <= {DEV_ADDR, 1'b0};
                    end
                end
                S_WR_DEV: begin
                    if (cmd_done) begin
                        state_reg <= S_WR_ADDR;
                        i2c_req   <= 1'b1;
                        i2c_cmd   <= I2C_CMD_WRITE;
                        i2c_din   <= op_addr_reg;
                    end
                end
                S_WR_ADDR: begin
                    if (cmd_done) begin
                        i2c_req      <= 1'b1;
                        cnt_byte_reg <= '0;
                        if (op_wr_reg) begin
                            state_reg <= S_WR_DATA;
                            i2c_cmd   <= byte_cmd(1'b0, next_last);
                            i2c_din   <= wr_data;
                        end else begin
                            state_reg <= S_RD_DEV;
                            i2c_cmd   <= I2C_CMD_START | I2C_CMD_WRITE;
                            i2c_din   <= {DEV_ADDR, 1'b1};
                        end
                    end
                end
                S_WR_DATA: begin
                    if (cmd_done) begin
                        if (last_byte) begin
                            state_reg    <= S_TWR;
                            cmd_pend_reg <= 1'b0;
                            twr_cnt_reg  <= '0;
                        end else begin
                            cnt_byte_reg <= next_idx;
                            i2c_req      <= 1'b1;
                            i2c_cmd      <= byte_cmd(1'b0, next_last);
                            i2c_din      <= wr_data;
                        end
                    end
                end
                S_RD_DEV: begin
                    if (cmd_done) begin
                        state_reg    <= S_RD_DATA;
                        cnt_byte_reg <= '0;
                        i2c_req      <= 1'b1;
                        i2c_cmd      <= byte_cmd(1'b1, next_last);
                    end
                end
                S_RD_DATA: begin
                    if (fin_reg) begin
                        fin_reg   <= 1'b0;
                        op_rdy    <= 1'b1;
                        state_reg <= S_IDLE;
                    end else if (cmd_done) begin
                        rd_data <= i2c_dout;
                        rd_vld  <= 1'b1;
                        if (last_byte) begin
                            op_done      <= 1'b1;
                            fin_reg      <= 1'b1;
                            cmd_pend_reg <= 1'b0;
                        end else begin
                            cnt_byte_reg <= next_idx;
                            i2c_req      <= 1'b1;
                            i2c_cmd      <= byte_cmd(1'b1, next_last);
                        end
                    end
                end
                S_TWR: begin
                    // op_done marks the last wait cycle; IDLE follows one cycle later.
                    if (fin_reg) begin
                        fin_reg   <= 1'b0;
                        op_rdy    <= 1'b1;
                        state_reg <= S_IDLE;
                    end else if (twr_cnt_reg == TWR_W'(TWR_CYC - 1)) begin
                        op_done <= 1'b1;
                        fin_reg <= 1'b1;
                    end else begin
                        twr_cnt_reg <= twr_cnt_reg + TWR_W'(1);
                    end
                end
                default: begin
                    state_reg    <= S_IDLE;
                    op_rdy       <= 1'b1;
                    cmd_pend_reg <= 1'b0;
                    fin_reg      <= 1'b0;
                end
            endcase
        end
    end

endmodule
